alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, registered successor to the team's 4-bit combinational ALU. It keeps the same operand/select interface and extends it with:
- `WIDTH`-bit operands;
- XOR, shift-left and multi-cycle multiply operations;
- status flags;
- a valid/ready handshake on both input and output.

It sits between an operand-issuing controller and a result consumer, with exactly one operation in flight.

## Interface
- `WIDTH`, default 4: operand/result width; must be a power of two, ≥4.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: A/B/sel are valid this cycle.
- `in_ready`  out  1: block accepts an operation this cycle.
- `A`  in  WIDTH: operand A.
- `B`  in  WIDTH: operand B (its low log2(WIDTH) bits are the shift amount for SHL).
- `sel`  in  3: operation code.
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT A.
  - 101 XOR, 110 SHL, 111 MUL.
- `out_valid`  out  1: result and flags are valid.
- `out_ready`  in  1: consumer takes the result this cycle.
- `Y`  out  WIDTH: result; low half of the product for MUL.
- `Y_hi`  out  WIDTH: high half of the product for MUL; 0 for every other op.
- `zero`  out  1: result is zero. For MUL this means the full 2×WIDTH product is zero.
- `carry`  out  1: carry/borrow flag; rules under Operation.
- `negative`  out  1: `Y[WIDTH-1]`.
- `overflow`  out  1: signed overflow for ADD/SUB; 0 otherwise.

## Operation
- State machine with three states: IDLE, BUSY (MUL in progress), DONE (result held).
- An operation is accepted on any edge where `in_valid && in_ready`.
- `in_ready` = (state==IDLE) || (state==DONE && out_ready). This gives back-to-back acceptance with no bubble.
- Single-cycle ops (sel ≠ 111): on acceptance, compute and register the result and flags, then go to DONE.
- MUL:
  - On acceptance, go to BUSY and start an unsigned shift-add multiply, one partial-product step per cycle, `WIDTH` steps.
  - After the last step, register the product and go to DONE.
  - A and B are captured at acceptance; later input changes have no effect.
- DONE:
  - `out_valid`=1.
  - `Y`, `Y_hi` and all flags are held stable until `out_ready`.
  - On `out_ready` with no new acceptance, go to IDLE.
  - On `out_ready` with a simultaneous acceptance, load the new op in the same cycle: DONE for a single-cycle op, BUSY for MUL.
- Arithmetic is modulo 2^WIDTH for `Y`.
- ADD flags:
  - `carry` = bit WIDTH of A+B.
  - `overflow` = (A[msb]==B[msb]) && (Y[msb]!=A[msb]).
- SUB flags:
  - `carry` = borrow, i.e. A<B unsigned.
  - `overflow` = (A[msb]!=B[msb]) && (Y[msb]!=A[msb]).
- MUL flags: `carry` = |Y_hi.
- AND/OR/NOT/XOR/SHL: `carry`=0, `overflow`=0.
- SHL: `Y` = A << B[log2(WIDTH)-1:0], zero-filled.
- `Y_hi`=0 for every op except MUL.
- Reset:
  - `rst` in any state, including BUSY mid-multiply, aborts the operation and enters IDLE on that edge.
  - No stale result is ever presented after reset.
- Reset values: `in_ready`=1 from the first cycle after reset; `out_valid`, `Y`, `Y_hi`, `zero`, `carry`, `negative`, `overflow` all 0.

## Timing
- Single-cycle op accepted at edge k: `out_valid`=1 after edge k, i.e. a latency of 1.
- MUL accepted at edge k: `out_valid`=1 after edge k+WIDTH, i.e. a latency of WIDTH+1 cycles. `in_ready`=0 throughout BUSY.
- Throughput with `out_ready` held at 1:
  - single-cycle ops: one per cycle;
  - MUL: one per WIDTH+1 cycles.
- Outputs are registered only; there is no combinational path from `A`, `B` or `sel` to any output.
- `in_ready` depends combinationally on `out_ready` (DONE pass-through only).

## Structure
- Shared package `alu_seq_pkg` holds:
  - the op-code constants (OP_ADD … OP_MUL, 3 bits);
  - the state encoding (IDLE, BUSY, DONE).
- One sub-module, `alu_seq_mul`: an iterative unsigned shift-add multiplier.
  - Interface: `clk`, `rst`, `start`, A, B → `done` pulse and 2×WIDTH product.
  - The top-level owns the FSM, the combinational op datapath, the flag logic and the output registers.

## Test plan
All scenarios use WIDTH=4.
- ADD: A=0101, B=0011, sel=000, `out_ready`=1 → one cycle later `Y`=1000, `carry`=0, `overflow`=1, `negative`=1, `zero`=0.
- SUB:
  - A=0011, B=0101, sel=001 → `Y`=1110, `carry`=1, `overflow`=0, `negative`=1.
  - A=0101, B=0101 → `Y`=0000, `zero`=1.
- Back-to-back ops, `in_valid` held with AND, OR, NOT, XOR, SHL (A=0101, B=0011, B=0001 for SHL) → results 0001, 0111, 1010, 0110, 1010 on consecutive cycles, `in_ready` never low.
- MUL: A=1111, B=1111 → `in_ready` low for 4 cycles; `out_valid` exactly 5 cycles after acceptance with `Y`=0001, `Y_hi`=1110, `carry`=1, `zero`=0.
- Backpressure:
  - Complete an ADD with `out_ready`=0 for 3 cycles → `out_valid`, `Y` and flags stable and `in_ready`=0 throughout.
  - Raise `out_ready` together with a new `in_valid` → new op accepted on that edge.
- Reset mid-MUL: assert `rst` 2 cycles into BUSY → next cycle `out_valid`=0, `Y`=`Y_hi`=0, `in_ready`=1, and no result is ever emitted for the aborted op.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared op-codes and FSM state encoding for the sequential ALU.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_NOT = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH steps.
module alu_seq_mul #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    logic               busy;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;

    always_comb begin
        acc_next = acc;
        if (mplier[0])
            acc_next = acc + mcand;
    end

    // The final step's sum is exposed directly so the caller can register it on the done edge.
    assign done    = busy && (cnt == CW'(WIDTH-1));
    assign product = acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, status flags and a multi-cycle multiply.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Y_hi,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow
);

    localparam int SHW = $clog2(WIDTH);

    state_e             state, state_next;
    logic               accept;
    logic               is_mul;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   res;
    logic               res_carry;
    logic               res_ovf;

    assign is_mul    = (op_e'(sel) == OP_MUL);
    assign in_ready  = (state == S_IDLE) || (state == S_DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_DONE);

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept) state_next = is_mul ? S_BUSY : S_DONE;
            S_BUSY: if (mul_done) state_next = S_DONE;
            S_DONE: begin
                if (accept)
                    state_next = is_mul ? S_BUSY : S_DONE;
                else if (out_ready)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Single-cycle datapath; borrow falls out of the extended subtraction's top bit.
    always_comb begin
        sum       = {1'b0, A} + {1'b0, B};
        diff      = {1'b0, A} - {1'b0, B};
        res       = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        case (op_e'(sel))
            OP_ADD: begin
                res       = sum[WIDTH-1:0];
                res_carry = sum[WIDTH];
                res_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                res       = diff[WIDTH-1:0];
                res_carry = diff[WIDTH];
                res_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  res = A & B;
            OP_OR:   res = A | B;
            OP_NOT:  res = ~A;
            OP_XOR:  res = A ^ B;
            OP_SHL:  res = A << B[SHW-1:0];
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Y        <= '0;
            Y_hi     <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            negative <= 1'b0;
            overflow <= 1'b0;
        end else if (accept && !is_mul) begin
            Y        <= res;
            Y_hi     <= '0;
            zero     <= (res == '0);
            carry    <= res_carry;
            negative <= res[WIDTH-1];
            overflow <= res_ovf;
        end else if (state == S_BUSY && mul_done) begin
            Y        <= mul_prod[WIDTH-1:0];
            Y_hi     <= mul_prod[2*WIDTH-1:WIDTH];
            zero     <= (mul_prod == '0);
            carry    <= |mul_prod[2*WIDTH-1:WIDTH];
            negative <= mul_prod[WIDTH-1];
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=4 with hand-computed expectations.
module tb_alu_seq;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A, B;
    logic [2:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Y, Y_hi;
    logic             zero, carry, negative, overflow;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .Y_hi      (Y_hi),
        .zero      (zero),
        .carry     (carry),
        .negative  (negative),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic [3:0] y, input logic [3:0] yh,
                           input logic z, input logic c, input logic n, input logic v);
        chk({tag, ".valid"}, 8'(out_valid), 8'd1);
        chk({tag, ".Y"},     8'(Y),         8'(y));
        chk({tag, ".Y_hi"},  8'(Y_hi),      8'(yh));
        chk({tag, ".flags"}, 8'({zero, carry, negative, overflow}), 8'({z, c, n, v}));
    endtask

    logic [2:0] b2b_sel [5] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
    logic [3:0] b2b_b   [5] = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0001};
    logic [3:0] b2b_y   [5] = '{4'b0001, 4'b0111, 4'b1010, 4'b0110, 4'b1010};

    initial begin
        int bad;
        int lat;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; sel = '0;
        tick(); tick();
        rst = 1'b0;
        chk("reset.out_valid", 8'(out_valid), 8'd0);
        chk("reset.in_ready",  8'(in_ready),  8'd1);
        chk("reset.Y",         8'({Y_hi, Y}), 8'd0);
        chk("reset.flags",     8'({zero, carry, negative, overflow}), 8'd0);

        // ADD 5+3 = 8: signed overflow, negative
        A = 4'b0101; B = 4'b0011; sel = 3'b000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk_res("add", 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();

        // SUB 3-5 borrows; SUB 5-5 is zero
        A = 4'b0011; B = 4'b0101; sel = 3'b001; in_valid = 1'b1;
        tick();
        chk_res("sub_borrow", 4'b1110, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        A = 4'b0101; B = 4'b0101;
        tick();
        chk_res("sub_zero", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);

        // Back-to-back logic ops with in_valid held
        A = 4'b0101;
        for (int i = 0; i < 5; i++) begin
            sel = b2b_sel[i]; B = b2b_b[i];
            chk($sformatf("b2b%0d.in_ready", i), 8'(in_ready), 8'd1);
            tick();
            chk_res($sformatf("b2b%0d", i), b2b_y[i], 4'b0000, 1'b0, 1'b0, b2b_y[i][3], 1'b0);
        end

        // MUL 15*15 = 225 = 0xE1, accepted straight out of DONE
        A = 4'b1111; B = 4'b1111; sel = 3'b111;
        tick();
        in_valid = 1'b0; A = '0; B = '0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
            if (i < 3) tick();
        end
        chk("mul.busy_window", 8'(bad), 8'd0);
        tick();
        chk_res("mul", 4'b0001, 4'b1110, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("mul.drain", 8'(out_valid), 8'd0);

        // Backpressure: ADD 7+1 held for 3 cycles while a second op waits
        out_ready = 1'b0;
        A = 4'b0111; B = 4'b0001; sel = 3'b000; in_valid = 1'b1;
        tick();
        A = 4'b0010; B = 4'b0010;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (out_valid !== 1'b1 || Y !== 4'b1000 || in_ready !== 1'b0 ||
                {zero, carry, negative, overflow} !== 4'b0011) bad++;
            tick();
        end
        chk("stall.hold", 8'(bad), 8'd0);
        chk_res("stall.final", 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
        out_ready = 1'b1;
        #1;
        chk("release.in_ready", 8'(in_ready), 8'd1);
        tick();
        in_valid = 1'b0;
        chk_res("release.add", 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Reset two cycles into a MUL
        A = 4'b0011; B = 4'b0011; sel = 3'b111; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mul.out_valid", 8'(out_valid), 8'd0);
        chk("rst_mul.Y",         8'({Y_hi, Y}), 8'd0);
        chk("rst_mul.in_ready",  8'(in_ready),  8'd1);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid !== 1'b0) bad++;
            tick();
        end
        chk("rst_mul.no_result", 8'(bad), 8'd0);

        // Recovery: MUL 3*3 = 9, latency bounded
        A = 4'b0011; B = 4'b0011; sel = 3'b111; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("mul2.latency", 8'(lat), 8'd5);
        chk_res("mul2", 4'b1001, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
